// File: rtl/reg_writeback.sv
// Writeback stage: retires Ex results and load responses onto the register-file write port.
// Latency: one cycle to o_int_reg_wb; o_stall holds upstream while a load is outstanding or draining.
module reg_writeback #(
    parameter int XLEN = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_ex_valid,
    input  logic              i_ex_rd_valid,
    input  logic [4:0]        i_ex_rd_idx,
    input  logic              i_ex_is_load,
    input  logic [XLEN-1:0]   i_ex_data,
    input  logic              i_ld_valid,
    input  logic [XLEN-1:0]   i_ld_data,
    output logic              o_stall,
    output logic [XLEN+5:0]   o_int_reg_wb,
    output logic [31:0]       o_busy_mask,
    output logic [31:0]       o_retire_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LD = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              wb_vld_q, wb_vld_d;
    logic [4:0]        wb_idx_q, wb_idx_d;
    logic [XLEN-1:0]   wb_dat_q, wb_dat_d;
    logic [31:0]       busy_q, busy_d;
    logic [31:0]       retire_cnt_q, retire_cnt_d;
    logic              ld_rd_vld_q, ld_rd_vld_d;
    logic [4:0]        ld_rd_idx_q, ld_rd_idx_d;
    logic              ex_writes_rd;

    // x0 is hardwired zero, so a write to it is never presented to the register file.
    assign ex_writes_rd = i_ex_rd_valid && (i_ex_rd_idx != 5'd0);

    always_comb begin
        state_d      = state_q;
        wb_vld_d     = 1'b0;
        wb_idx_d     = wb_idx_q;
        wb_dat_d     = wb_dat_q;
        busy_d       = busy_q;
        retire_cnt_d = retire_cnt_q;
        ld_rd_vld_d  = ld_rd_vld_q;
        ld_rd_idx_d  = ld_rd_idx_q;

        case (state_q)
            IDLE: begin
                if (i_ex_valid && !i_flush) begin
                    if (i_ex_is_load) begin
                        state_d     = WAIT_LD;
                        ld_rd_vld_d = ex_writes_rd;
                        ld_rd_idx_d = i_ex_rd_idx;
                        busy_d      = ex_writes_rd ? (32'd1 << i_ex_rd_idx) : 32'd0;
                    end else begin
                        wb_vld_d     = ex_writes_rd;
                        wb_idx_d     = i_ex_rd_idx;
                        wb_dat_d     = i_ex_data;
                        retire_cnt_d = retire_cnt_q + 32'd1;
                    end
                end
            end
            WAIT_LD: begin
                if (i_flush) begin
                    // A response coinciding with the flush is dropped outright; otherwise wait to swallow it.
                    busy_d  = 32'd0;
                    state_d = i_ld_valid ? IDLE : DRAIN;
                end else if (i_ld_valid) begin
                    wb_vld_d     = ld_rd_vld_q;
                    wb_idx_d     = ld_rd_idx_q;
                    wb_dat_d     = i_ld_data;
                    busy_d       = 32'd0;
                    retire_cnt_d = retire_cnt_q + 32'd1;
                    state_d      = IDLE;
                end
            end
            DRAIN: begin
                if (i_ld_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 32'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            wb_vld_q     <= 1'b0;
            wb_idx_q     <= 5'd0;
            wb_dat_q     <= '0;
            busy_q       <= 32'd0;
            retire_cnt_q <= 32'd0;
            ld_rd_vld_q  <= 1'b0;
            ld_rd_idx_q  <= 5'd0;
        end else begin
            state_q      <= state_d;
            wb_vld_q     <= wb_vld_d;
            wb_idx_q     <= wb_idx_d;
            wb_dat_q     <= wb_dat_d;
            busy_q       <= busy_d;
            retire_cnt_q <= retire_cnt_d;
            ld_rd_vld_q  <= ld_rd_vld_d;
            ld_rd_idx_q  <= ld_rd_idx_d;
        end
    end

    assign o_stall      = (state_q != IDLE);
    assign o_int_reg_wb = {wb_vld_q, wb_idx_q, wb_dat_q};
    assign o_busy_mask  = busy_q;
    assign o_retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback; write-back port layout is {valid, idx[4:0], data[31:0]}.
module tb_reg_writeback;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         ex_valid;
    logic         ex_rd_valid;
    logic [4:0]   ex_rd_idx;
    logic         ex_is_load;
    logic [31:0]  ex_data;
    logic         ld_valid;
    logic [31:0]  ld_data;
    logic         stall;
    logic [37:0]  wb;
    logic [31:0]  busy;
    logic [31:0]  retire_cnt;

    int checks   = 0;
    int failures = 0;

    reg_writeback #(.XLEN(32)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_flush       (flush),
        .i_ex_valid    (ex_valid),
        .i_ex_rd_valid (ex_rd_valid),
        .i_ex_rd_idx   (ex_rd_idx),
        .i_ex_is_load  (ex_is_load),
        .i_ex_data     (ex_data),
        .i_ld_valid    (ld_valid),
        .i_ld_data     (ld_data),
        .o_stall       (stall),
        .o_int_reg_wb  (wb),
        .o_busy_mask   (busy),
        .o_retire_cnt  (retire_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush       = 1'b0;
        ex_valid    = 1'b0;
        ex_rd_valid = 1'b0;
        ex_rd_idx   = 5'd0;
        ex_is_load  = 1'b0;
        ex_data     = 32'd0;
        ld_valid    = 1'b0;
        ld_data     = 32'd0;
    endtask

    task automatic drive_ex(input logic load, input logic rdv, input logic [4:0] idx, input logic [31:0] dat);
        ex_valid    = 1'b1;
        ex_is_load  = load;
        ex_rd_valid = rdv;
        ex_rd_idx   = idx;
        ex_data     = dat;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        check("rst_wb",     {26'd0, wb},   64'd0);
        check("rst_busy",   busy,          64'd0);
        check("rst_cnt",    retire_cnt,    64'd0);
        check("rst_stall",  stall,         64'd0);
        rst_n = 1'b1;

        // ALU write to x5
        drive_ex(1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        idle_inputs();
        check("alu_wb",    wb,         {1'b1, 5'd5, 32'hDEADBEEF});
        check("alu_cnt",   retire_cnt, 64'd1);
        check("alu_stall", stall,      64'd0);
        step();
        check("alu_wb_pulse", wb[37], 64'd0);

        // x0 destination retires without a write
        drive_ex(1'b0, 1'b1, 5'd0, 32'h00001234);
        step();
        idle_inputs();
        check("x0_vld", wb[37],     64'd0);
        check("x0_cnt", retire_cnt, 64'd2);

        // rd_valid=0 retires without a write
        drive_ex(1'b0, 1'b0, 5'd4, 32'h0000AAAA);
        step();
        idle_inputs();
        check("nord_vld", wb[37],     64'd0);
        check("nord_cnt", retire_cnt, 64'd3);

        // Flush in IDLE discards the input
        drive_ex(1'b0, 1'b1, 5'd6, 32'h11112222);
        flush = 1'b1;
        step();
        idle_inputs();
        check("flush_idle_vld", wb[37],     64'd0);
        check("flush_idle_cnt", retire_cnt, 64'd3);

        // Stray load response in IDLE is ignored
        ld_valid = 1'b1;
        ld_data  = 32'h99999999;
        step();
        idle_inputs();
        check("stray_ld_vld",   wb[37],     64'd0);
        check("stray_ld_stall", stall,      64'd0);
        check("stray_ld_cnt",   retire_cnt, 64'd3);

        // Load to x7; a competing Ex input while waiting must be ignored
        drive_ex(1'b1, 1'b1, 5'd7, 32'hFFFFFFFF);
        step();
        drive_ex(1'b0, 1'b1, 5'd2, 32'h0BADF00D);
        for (int i = 0; i < 3; i++) begin
            check("ld_wait_stall", stall,  64'd1);
            check("ld_wait_busy",  busy,   64'h80);
            check("ld_wait_vld",   wb[37], 64'd0);
            step();
        end
        idle_inputs();
        ld_valid = 1'b1;
        ld_data  = 32'hCAFEF00D;
        step();
        idle_inputs();
        check("ld_wb",    wb,         {1'b1, 5'd7, 32'hCAFEF00D});
        check("ld_busy",  busy,       64'd0);
        check("ld_stall", stall,      64'd0);
        check("ld_cnt",   retire_cnt, 64'd4);

        // Flush while a load to x3 is outstanding
        drive_ex(1'b1, 1'b1, 5'd3, 32'd0);
        step();
        idle_inputs();
        check("fl_ld_busy", busy, 64'h8);
        flush = 1'b1;
        step();
        idle_inputs();
        check("drain_stall", stall, 64'd1);
        check("drain_busy",  busy,  64'd0);
        flush = 1'b1;
        step();
        idle_inputs();
        check("drain_hold_stall", stall, 64'd1);
        ld_valid = 1'b1;
        ld_data  = 32'h00000055;
        step();
        idle_inputs();
        check("drain_vld",   wb[37],     64'd0);
        check("drain_cnt",   retire_cnt, 64'd4);
        check("drain_stall", stall,      64'd0);

        // Flush and response in the same cycle: dropped, back to IDLE directly
        drive_ex(1'b1, 1'b1, 5'd10, 32'd0);
        step();
        idle_inputs();
        check("same_busy_set", busy, 64'h400);
        flush    = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 32'h12121212;
        step();
        idle_inputs();
        check("same_vld",   wb[37],     64'd0);
        check("same_busy",  busy,       64'd0);
        check("same_stall", stall,      64'd0);
        check("same_cnt",   retire_cnt, 64'd4);

        // Retire counter wraps
        force dut.retire_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt_q;
        #1;
        check("wrap_pre", retire_cnt, 64'hFFFFFFFF);
        drive_ex(1'b0, 1'b1, 5'd1, 32'h00000001);
        step();
        idle_inputs();
        check("wrap_cnt", retire_cnt, 64'd0);
        check("wrap_wb",  wb,         {1'b1, 5'd1, 32'h00000001});

        // Reset during WAIT_LD abandons the load
        drive_ex(1'b1, 1'b1, 5'd9, 32'd0);
        step();
        idle_inputs();
        check("rl_busy", busy, 64'h200);
        rst_n = 1'b0;
        flush = 1'b1;
        step();
        idle_inputs();
        rst_n = 1'b1;
        check("rl_wb",    {26'd0, wb}, 64'd0);
        check("rl_busy0", busy,        64'd0);
        check("rl_cnt",   retire_cnt,  64'd0);
        check("rl_stall", stall,       64'd0);
        ld_valid = 1'b1;
        ld_data  = 32'h77777777;
        step();
        idle_inputs();
        check("rl_late_vld", wb[37],     64'd0);
        check("rl_late_cnt", retire_cnt, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
